// File: rtl/axi_wr_arbiter.sv
// AXI3 write-port arbiter: NUM_MST masters onto one slave (round-robin AW, AW-ordered W, ID-routed B).
// Define AXI_WR_ARB_PERF_CNT_EN to add the grant_cnt_o / stall_cnt_o performance counters.
module axi_wr_arbiter #(
    parameter int unsigned NUM_MST  = 2,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WQ_DEPTH = 4,
    localparam int unsigned MSEL_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1,
    localparam int unsigned STRB_W  = DATA_W / 8,
    localparam int unsigned SID_W   = ID_W + MSEL_W
) (
    input  logic                        aclk_i,
    input  logic                        arstn_i,
    input  logic [NUM_MST*ID_W-1:0]     m_awid_i,
    input  logic [NUM_MST*ADDR_W-1:0]   m_awaddr_i,
    input  logic [NUM_MST*4-1:0]        m_awlen_i,
    input  logic [NUM_MST*3-1:0]        m_awsize_i,
    input  logic [NUM_MST*2-1:0]        m_awburst_i,
    input  logic [NUM_MST*2-1:0]        m_awlock_i,
    input  logic [NUM_MST*4-1:0]        m_awcache_i,
    input  logic [NUM_MST*3-1:0]        m_awprot_i,
    input  logic [NUM_MST-1:0]          m_awvalid_i,
    output logic [NUM_MST-1:0]          m_awready_o,
    input  logic [NUM_MST*ID_W-1:0]     m_wid_i,
    input  logic [NUM_MST*DATA_W-1:0]   m_wdata_i,
    input  logic [NUM_MST*STRB_W-1:0]   m_wstrb_i,
    input  logic [NUM_MST-1:0]          m_wlast_i,
    input  logic [NUM_MST-1:0]          m_wvalid_i,
    output logic [NUM_MST-1:0]          m_wready_o,
    output logic [NUM_MST*ID_W-1:0]     m_bid_o,
    output logic [NUM_MST*2-1:0]        m_bresp_o,
    output logic [NUM_MST-1:0]          m_bvalid_o,
    input  logic [NUM_MST-1:0]          m_bready_i,
    output logic [SID_W-1:0]            s_awid_o,
    output logic [ADDR_W-1:0]           s_awaddr_o,
    output logic [3:0]                  s_awlen_o,
    output logic [2:0]                  s_awsize_o,
    output logic [1:0]                  s_awburst_o,
    output logic [1:0]                  s_awlock_o,
    output logic [3:0]                  s_awcache_o,
    output logic [2:0]                  s_awprot_o,
    output logic                        s_awvalid_o,
    input  logic                        s_awready_i,
    output logic [SID_W-1:0]            s_wid_o,
    output logic [DATA_W-1:0]           s_wdata_o,
    output logic [STRB_W-1:0]           s_wstrb_o,
    output logic                        s_wlast_o,
    output logic                        s_wvalid_o,
    input  logic                        s_wready_i,
    input  logic [SID_W-1:0]            s_bid_i,
    input  logic [1:0]                  s_bresp_i,
    input  logic                        s_bvalid_i,
    output logic                        s_bready_o
`ifdef AXI_WR_ARB_PERF_CNT_EN
    ,
    output logic [NUM_MST*16-1:0]       grant_cnt_o,
    output logic [15:0]                 stall_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state_q;
    logic [MSEL_W-1:0]   win_q;
    logic [MSEL_W-1:0]   rr_q;
    logic [MSEL_W-1:0]   rr_next;
    logic [MSEL_W-1:0]   rr_win;
    logic [MSEL_W-1:0]   cand;
    logic                rr_any;

    logic [MSEL_W-1:0]   fifo_q [WQ_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic [MSEL_W-1:0]   w_sel;
    logic [MSEL_W-1:0]   b_sel;

    logic                aw_hs;
    logic                w_pop;

    assign fifo_full  = (cnt_q == CNT_W'(WQ_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign w_sel      = fifo_q[rd_ptr_q];
    assign b_sel      = s_bid_i[ID_W +: MSEL_W];
    assign rr_next    = (win_q == MSEL_W'(NUM_MST - 1)) ? '0 : win_q + 1'b1;

    // Scan from the highest offset down so the nearest requester at/after rr_q wins.
    always_comb begin
        rr_win = rr_q;
        rr_any = 1'b0;
        cand   = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            cand = MSEL_W'((int'(rr_q) + k) % int'(NUM_MST));
            if (m_awvalid_i[cand]) begin
                rr_win = cand;
                rr_any = 1'b1;
            end
        end
    end

    always_comb begin
        s_awid_o    = '0;
        s_awaddr_o  = '0;
        s_awlen_o   = '0;
        s_awsize_o  = '0;
        s_awburst_o = '0;
        s_awlock_o  = '0;
        s_awcache_o = '0;
        s_awprot_o  = '0;
        s_awvalid_o = 1'b0;
        m_awready_o = '0;
        if (state_q == StGrant) begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (win_q == MSEL_W'(i)) begin
                    s_awid_o       = {win_q, m_awid_i[i*ID_W +: ID_W]};
                    s_awaddr_o     = m_awaddr_i[i*ADDR_W +: ADDR_W];
                    s_awlen_o      = m_awlen_i[i*4 +: 4];
                    s_awsize_o     = m_awsize_i[i*3 +: 3];
                    s_awburst_o    = m_awburst_i[i*2 +: 2];
                    s_awlock_o     = m_awlock_i[i*2 +: 2];
                    s_awcache_o    = m_awcache_i[i*4 +: 4];
                    s_awprot_o     = m_awprot_i[i*3 +: 3];
                    s_awvalid_o    = m_awvalid_i[i];
                    m_awready_o[i] = s_awready_i;
                end
            end
        end
    end

    assign aw_hs = (state_q == StGrant) && s_awvalid_o && s_awready_i;

    // W follows the FIFO head only; an empty FIFO blocks all masters.
    always_comb begin
        s_wid_o    = '0;
        s_wdata_o  = '0;
        s_wstrb_o  = '0;
        s_wlast_o  = 1'b0;
        s_wvalid_o = 1'b0;
        m_wready_o = '0;
        if (!fifo_empty) begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (w_sel == MSEL_W'(i)) begin
                    s_wid_o       = {w_sel, m_wid_i[i*ID_W +: ID_W]};
                    s_wdata_o     = m_wdata_i[i*DATA_W +: DATA_W];
                    s_wstrb_o     = m_wstrb_i[i*STRB_W +: STRB_W];
                    s_wlast_o     = m_wlast_i[i];
                    s_wvalid_o    = m_wvalid_i[i];
                    m_wready_o[i] = s_wready_i;
                end
            end
        end
    end

    assign w_pop = !fifo_empty && s_wvalid_o && s_wready_i && s_wlast_o;

    // Responses carrying an out-of-range master index are sunk.
    always_comb begin
        m_bid_o    = '0;
        m_bresp_o  = '0;
        m_bvalid_o = '0;
        s_bready_o = 1'b1;
        for (int i = 0; i < NUM_MST; i++) begin
            if (b_sel == MSEL_W'(i)) begin
                m_bid_o[i*ID_W +: ID_W] = s_bid_i[ID_W-1:0];
                m_bresp_o[i*2 +: 2]     = s_bresp_i;
                m_bvalid_o[i]           = s_bvalid_i;
                s_bready_o              = m_bready_i[i];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (aw_hs && !w_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!aw_hs && w_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge aclk_i) begin
        if (!arstn_i) begin
            state_q  <= StIdle;
            win_q    <= '0;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rr_any && !fifo_full) begin
                        win_q   <= rr_win;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    if (aw_hs) begin
                        rr_q    <= rr_next;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (aw_hs) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge aclk_i) begin
        if (aw_hs) begin
            fifo_q[wr_ptr_q] <= win_q;
        end
    end

`ifdef AXI_WR_ARB_PERF_CNT_EN
    logic [15:0] grant_cnt_q [NUM_MST];
    logic [15:0] stall_cnt_q;

    always_ff @(posedge aclk_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < NUM_MST; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (aw_hs && (win_q == MSEL_W'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
            if ((state_q == StIdle) && rr_any && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            grant_cnt_o[i*16 +: 16] = grant_cnt_q[i];
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter (2 masters): per-master stimulus queues drive AW/W,
// a scoreboard checks slave-side AW/W order; B routing and reset are checked directly.
module tb_axi_wr_arbiter;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
    } aw_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } w_t;

    logic aclk = 1'b0;
    logic arstn;

    logic [7:0]  m_awid;
    logic [63:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [5:0]  m_awsize;
    logic [3:0]  m_awburst;
    logic [3:0]  m_awlock;
    logic [7:0]  m_awcache;
    logic [5:0]  m_awprot;
    logic [1:0]  m_awvalid;
    logic [1:0]  m_awready;
    logic [7:0]  m_wid;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_wlast;
    logic [1:0]  m_wvalid;
    logic [1:0]  m_wready;
    logic [7:0]  m_bid;
    logic [3:0]  m_bresp;
    logic [1:0]  m_bvalid;
    logic [1:0]  m_bready;
    logic [4:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic [1:0]  s_awlock;
    logic [3:0]  s_awcache;
    logic [2:0]  s_awprot;
    logic        s_awvalid;
    logic        s_awready;
    logic [4:0]  s_wid;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [4:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
`ifdef AXI_WR_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt;
    logic [15:0] stall_cnt;
    logic [15:0] stall0;
`endif

    aw_t aw_q0[$];
    aw_t aw_q1[$];
    w_t  w_q0[$];
    w_t  w_q1[$];
    logic [40:0] exp_aw[$];
    logic [37:0] exp_w[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit space_en = 1'b0;
    bit m0_loaded;

    axi_wr_arbiter dut (
`ifdef AXI_WR_ARB_PERF_CNT_EN
        .grant_cnt_o (grant_cnt),
        .stall_cnt_o (stall_cnt),
`endif
        .aclk_i      (aclk),
        .arstn_i     (arstn),
        .m_awid_i    (m_awid),
        .m_awaddr_i  (m_awaddr),
        .m_awlen_i   (m_awlen),
        .m_awsize_i  (m_awsize),
        .m_awburst_i (m_awburst),
        .m_awlock_i  (m_awlock),
        .m_awcache_i (m_awcache),
        .m_awprot_i  (m_awprot),
        .m_awvalid_i (m_awvalid),
        .m_awready_o (m_awready),
        .m_wid_i     (m_wid),
        .m_wdata_i   (m_wdata),
        .m_wstrb_i   (m_wstrb),
        .m_wlast_i   (m_wlast),
        .m_wvalid_i  (m_wvalid),
        .m_wready_o  (m_wready),
        .m_bid_o     (m_bid),
        .m_bresp_o   (m_bresp),
        .m_bvalid_o  (m_bvalid),
        .m_bready_i  (m_bready),
        .s_awid_o    (s_awid),
        .s_awaddr_o  (s_awaddr),
        .s_awlen_o   (s_awlen),
        .s_awsize_o  (s_awsize),
        .s_awburst_o (s_awburst),
        .s_awlock_o  (s_awlock),
        .s_awcache_o (s_awcache),
        .s_awprot_o  (s_awprot),
        .s_awvalid_o (s_awvalid),
        .s_awready_i (s_awready),
        .s_wid_o     (s_wid),
        .s_wdata_o   (s_wdata),
        .s_wstrb_o   (s_wstrb),
        .s_wlast_o   (s_wlast),
        .s_wvalid_o  (s_wvalid),
        .s_wready_i  (s_wready),
        .s_bid_i     (s_bid),
        .s_bresp_i   (s_bresp),
        .s_bvalid_i  (s_bvalid),
        .s_bready_o  (s_bready)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ew(input int m, input logic [3:0] id, input int beat, input logic last);
        logic [31:0] d;
        d = 32'hD000_0000 + 32'(m) * 32'h1_0000 + {20'd0, id, 8'(beat)};
        exp_w.push_back({1'(m), id, d, last});
    endtask

    task automatic add_aw(input int m, input logic [3:0] id, input logic [3:0] len);
        aw_t a;
        a.id   = id;
        a.addr = 32'h1000_0000 + 32'(m) * 32'h1000 + {24'd0, id, len};
        a.len  = len;
        if (m == 0) aw_q0.push_back(a);
        else aw_q1.push_back(a);
        exp_aw.push_back({1'(m), id, a.addr, len});
    endtask

    task automatic add_w(input int m, input logic [3:0] id, input int beat, input logic last,
                         input bit exp);
        w_t w;
        w.id   = id;
        w.data = 32'hD000_0000 + 32'(m) * 32'h1_0000 + {20'd0, id, 8'(beat)};
        w.last = last;
        if (m == 0) w_q0.push_back(w);
        else w_q1.push_back(w);
        if (exp) ew(m, id, beat, last);
    endtask

    task automatic drive_masters();
        aw_t a0, a1;
        w_t  w0, w1;
        a0 = (aw_q0.size() != 0) ? aw_q0[0] : '0;
        a1 = (aw_q1.size() != 0) ? aw_q1[0] : '0;
        w0 = (w_q0.size() != 0) ? w_q0[0] : '0;
        w1 = (w_q1.size() != 0) ? w_q1[0] : '0;
        m_awvalid = {aw_q1.size() != 0, aw_q0.size() != 0};
        m_awid    = {a1.id, a0.id};
        m_awaddr  = {a1.addr, a0.addr};
        m_awlen   = {a1.len, a0.len};
        m_wvalid  = {w_q1.size() != 0, w_q0.size() != 0};
        m_wid     = {w1.id, w0.id};
        m_wdata   = {w1.data, w0.data};
        m_wlast   = {w1.last, w0.last};
    endtask

    function automatic bit busy();
        return (aw_q0.size() + aw_q1.size() + w_q0.size() + w_q1.size()) != 0;
    endfunction

    // One clock: note handshakes at the negedge, retire them after the posedge.
    task automatic tick();
        logic [1:0] hs_aw, hs_w;
        @(negedge aclk);
        hs_aw = arstn ? (m_awvalid & m_awready) : 2'b00;
        hs_w  = arstn ? (m_wvalid & m_wready) : 2'b00;
        @(posedge aclk);
        #1;
        if (hs_aw[0]) void'(aw_q0.pop_front());
        if (hs_aw[1]) void'(aw_q1.pop_front());
        if (hs_w[0]) void'(w_q0.pop_front());
        if (hs_w[1]) void'(w_q1.pop_front());
        drive_masters();
    endtask

    // Scoreboard side: every slave-side handshake pops one expected entry.
    initial begin : monitor
        int  last_cyc;
        bit  have_last;
        have_last = 1'b0;
        last_cyc  = 0;
        forever begin
            @(negedge aclk);
            if (!space_en) have_last = 1'b0;
            if (arstn && s_awvalid && s_awready) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 64'(s_awid), 64'h1f);
                else chk("aw_beat", 64'({s_awid, s_awaddr, s_awlen}), 64'(exp_aw.pop_front()));
                if (space_en && have_last) chk("aw_spacing", 64'(cyc - last_cyc), 64'd2);
                last_cyc  = cyc;
                have_last = 1'b1;
            end
            if (arstn && s_wvalid && s_wready) begin
                if (exp_w.size() == 0) chk("w_unexpected", 64'(s_wid), 64'h1f);
                else chk("w_beat", 64'({s_wid, s_wdata, s_wlast}), 64'(exp_w.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arstn     = 1'b0;
        m_awsize  = {3'd2, 3'd2};
        m_awburst = {2'b01, 2'b01};
        m_awlock  = '0;
        m_awcache = '0;
        m_awprot  = '0;
        m_wstrb   = '1;
        m_bready  = '0;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        s_bid     = '0;
        s_bresp   = '0;
        s_bvalid  = 1'b0;

        // Reset with both masters requesting, then alternating grants with single-beat W.
        for (int k = 0; k < 4; k++) begin
            for (int m = 0; m < 2; m++) begin
                add_aw(m, 4'(m * 4 + k), 4'd0);
                add_w(m, 4'(m * 4 + k), 0, 1'b1, 1'b1);
            end
        end
        drive_masters();
        for (int t = 0; t < 3; t++) begin
            tick();
            #1;
            chk("rst_ctl", 64'({s_awvalid, m_awready, s_wvalid, m_wready, m_bvalid, s_bready}), 64'd0);
            chk("rst_payload", 64'({s_awid, s_awaddr, s_wdata[15:0]}), 64'd0);
        end
        arstn    = 1'b1;
        space_en = 1'b1;
        tick();
        #1;
        chk("first_grant", 64'(m_awready), 64'b01);
        for (int t = 0; t < 60 && busy(); t++) tick();
        chk("t2_drain", 64'(busy()), 64'd0);
        chk("t2_sb_empty", {32'(exp_aw.size()), 32'(exp_w.size())}, 64'd0);
        space_en = 1'b0;

        // M1 drives W before M0's, but W order must follow AW order.
        add_aw(0, 4'h3, 4'd3);
        add_aw(1, 4'h9, 4'd1);
        add_w(1, 4'h9, 0, 1'b0, 1'b0);
        add_w(1, 4'h9, 1, 1'b1, 1'b0);
        drive_masters();
        m0_loaded = 1'b0;
        for (int t = 0; t < 40 && (busy() || !m0_loaded); t++) begin
            tick();
            if (t == 3) begin
                for (int b = 0; b < 4; b++) add_w(0, 4'h3, b, b == 3, 1'b1);
                ew(1, 4'h9, 0, 1'b0);
                ew(1, 4'h9, 1, 1'b1);
                m0_loaded = 1'b1;
                drive_masters();
            end
            #1;
            if (!(m0_loaded && w_q0.size() == 0)) chk("t3_m1_wready", 64'(m_wready[1]), 64'd0);
        end
        chk("t3_drain", 64'(busy()), 64'd0);
        chk("t3_sb_empty", {32'(exp_aw.size()), 32'(exp_w.size())}, 64'd0);

        // Five AWs with W stalled: only the FIFO depth is accepted.
        s_wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            add_aw(0, 4'(k), 4'd0);
            add_w(0, 4'(k), 0, 1'b1, 1'b1);
        end
        drive_masters();
`ifdef AXI_WR_ARB_PERF_CNT_EN
        stall0 = stall_cnt;
`endif
        for (int t = 0; t < 30; t++) tick();
        #1;
        chk("t4_aw_left", 64'(aw_q0.size()), 64'd1);
        chk("t4_awready_blocked", 64'(m_awready), 64'd0);
`ifdef AXI_WR_ARB_PERF_CNT_EN
        chk("t4_stall_cnt_inc", 64'(stall_cnt > stall0), 64'd1);
`endif
        s_wready = 1'b1;
        for (int t = 0; t < 40 && busy(); t++) tick();
        chk("t4_drain", 64'(busy()), 64'd0);
        chk("t4_sb_empty", {32'(exp_aw.size()), 32'(exp_w.size())}, 64'd0);
`ifdef AXI_WR_ARB_PERF_CNT_EN
        chk("grant_cnt", 64'(grant_cnt), {32'd0, 16'd5, 16'd10});
`endif

        // B routing by the index bit above the master ID.
        s_bid    = {1'b1, 4'h5};
        s_bvalid = 1'b1;
        m_bready = 2'b10;
        #1;
        chk("t5_bvalid_m1", 64'(m_bvalid), 64'b10);
        chk("t5_bid_m1", 64'(m_bid[7:4]), 64'h5);
        chk("t5_bready_m1", 64'(s_bready), 64'd1);
        s_bid   = {1'b0, 4'hA};
        s_bresp = 2'b10;
        #1;
        chk("t5_bvalid_m0", 64'(m_bvalid), 64'b01);
        chk("t5_bid_bresp_m0", 64'({m_bid[3:0], m_bresp[1:0]}), 64'({4'hA, 2'b10}));
        chk("t5_bready_m0", 64'(s_bready), 64'd0);
        s_bvalid = 1'b0;
        m_bready = 2'b00;
        #1;
        chk("t5_bvalid_idle", 64'(m_bvalid), 64'd0);

        // Reset in the middle of a 4-beat burst.
        add_aw(0, 4'hE, 4'd3);
        for (int b = 0; b < 4; b++) add_w(0, 4'hE, b, b == 3, b < 2);
        drive_masters();
        for (int t = 0; t < 20 && w_q0.size() > 2; t++) tick();
        chk("t6_two_beats", 64'(w_q0.size()), 64'd2);
        arstn = 1'b0;
        tick();
        #1;
        chk("t6_fifo_empty", 64'({s_wvalid, m_wready, s_awvalid}), 64'd0);
        w_q0.delete();
        aw_q0.delete();
        arstn = 1'b1;
        add_aw(0, 4'h1, 4'd0);
        add_aw(1, 4'h2, 4'd0);
        drive_masters();
        tick();
        #1;
        chk("t6_rr_reset", 64'(m_awready), 64'b01);
        for (int t = 0; t < 20 && busy(); t++) tick();
        chk("t6_drain", 64'(busy()), 64'd0);
        chk("t6_sb_empty", {32'(exp_aw.size()), 32'(exp_w.size())}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
